// File: rtl/ptr_sync_status.sv
// ptr_sync_status
// Brings a remote-domain Gray pointer into the local clock domain and derives
// FIFO occupancy status from it. MODE=0 is the write side (level and full
// flags). MODE=1 is the read side (level and empty flags).
//
// Ports
//   clk              local clock, rising edge
//   rst_n            asynchronous active-low reset
//   gray_ptr_remote  remote Gray pointer (asynchronous to clk)
//   bin_ptr_local    local binary pointer next-value (synchronous to clk)
//   err_clr          clears the sticky error bits
//   ptr_sync_gray    synchronised remote Gray pointer
//   ptr_sync_bin     registered binary form of ptr_sync_gray
//   ptr_update       one-cycle pulse when ptr_sync_bin changes
//   level            occupancy, 0..DEPTH (raw value shown even if out of range)
//   flag             full (MODE=0) or empty (MODE=1)
//   almost_flag      almost-full (MODE=0) or almost-empty (MODE=1)
//   err              sticky {level_err, jump_err}
module ptr_sync_status #(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 0,
    parameter int AF_LEVEL    = (1 << ADDR_W) - 2,
    parameter int AE_LEVEL    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W:0]   gray_ptr_remote,
    input  logic [ADDR_W:0]   bin_ptr_local,
    input  logic              err_clr,
    output logic [ADDR_W:0]   ptr_sync_gray,
    output logic [ADDR_W:0]   ptr_sync_bin,
    output logic              ptr_update,
    output logic [ADDR_W:0]   level,
    output logic              flag,
    output logic              almost_flag,
    output logic [1:0]        err
);

    localparam int PW    = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AF_P    = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_P    = PW'(AE_LEVEL);

    // Read side comes out of reset reporting empty; write side reports not full.
    localparam logic FLAG_RST = (MODE != 0);

    logic [PW-1:0] sync_q [SYNC_STAGES];

    logic [PW-1:0] bin_d,   bin_q;
    logic          upd_d,   upd_q;
    logic [PW-1:0] level_d, level_q;
    logic          flag_d,  flag_q;
    logic          almost_d, almost_q;
    logic          jump_d;
    logic [1:0]    err_d,   err_q;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Plain flop chain: nothing may sit between stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gray_ptr_remote;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_comb begin
        bin_d  = gray2bin(sync_q[SYNC_STAGES-1]);
        upd_d  = (bin_d != bin_q);
        // Modulo distance travelled by the remote pointer in one update.
        jump_d = ((bin_d - bin_q) > DEPTH_P);

        // Level pairs the fresh local pointer with the already-registered
        // remote binary pointer; wrap is handled by modulo-2^PW subtraction.
        if (MODE == 0) begin
            level_d  = bin_ptr_local - bin_q;
            flag_d   = (level_d == DEPTH_P);
            almost_d = (level_d >= AF_P);
        end else begin
            level_d  = bin_q - bin_ptr_local;
            flag_d   = (level_d == '0);
            almost_d = (level_d <= AE_P);
        end

        // Clear first, then set, so an error coincident with err_clr survives.
        err_d = err_q;
        if (err_clr) begin
            err_d = 2'b00;
        end
        if (level_d > DEPTH_P) begin
            err_d[1] = 1'b1;
        end
        if (jump_d) begin
            err_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q    <= '0;
            upd_q    <= 1'b0;
            level_q  <= '0;
            flag_q   <= FLAG_RST;
            almost_q <= FLAG_RST;
            err_q    <= 2'b00;
        end else begin
            bin_q    <= bin_d;
            upd_q    <= upd_d;
            level_q  <= level_d;
            flag_q   <= flag_d;
            almost_q <= almost_d;
            err_q    <= err_d;
        end
    end

    assign ptr_sync_gray = sync_q[SYNC_STAGES-1];
    assign ptr_sync_bin  = bin_q;
    assign ptr_update    = upd_q;
    assign level         = level_q;
    assign flag          = flag_q;
    assign almost_flag   = almost_q;
    assign err           = err_q;

endmodule

// File: tb/tb_ptr_sync_status.sv
module tb_ptr_sync_status;

    localparam int ND = 4;
    localparam int MODE_C [ND] = '{0, 1, 0, 0};
    localparam int SYNC_C [ND] = '{2, 2, 3, 4};
    localparam int HMAX = 1024;

    logic       clk;
    logic       rst_n;
    logic [4:0] gray_in;
    logic [4:0] loc_in;
    logic       err_clr;

    logic [4:0] o_gray   [ND];
    logic [4:0] o_bin    [ND];
    logic       o_upd    [ND];
    logic [4:0] o_level  [ND];
    logic       o_flag   [ND];
    logic       o_almost [ND];
    logic [1:0] o_err    [ND];

    int total = 0;
    int bad   = 0;

    ptr_sync_status #(.ADDR_W(4), .SYNC_STAGES(2), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .gray_ptr_remote(gray_in), .bin_ptr_local(loc_in),
        .err_clr(err_clr), .ptr_sync_gray(o_gray[0]), .ptr_sync_bin(o_bin[0]),
        .ptr_update(o_upd[0]), .level(o_level[0]), .flag(o_flag[0]),
        .almost_flag(o_almost[0]), .err(o_err[0]));

    ptr_sync_status #(.ADDR_W(4), .SYNC_STAGES(2), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .gray_ptr_remote(gray_in), .bin_ptr_local(loc_in),
        .err_clr(err_clr), .ptr_sync_gray(o_gray[1]), .ptr_sync_bin(o_bin[1]),
        .ptr_update(o_upd[1]), .level(o_level[1]), .flag(o_flag[1]),
        .almost_flag(o_almost[1]), .err(o_err[1]));

    ptr_sync_status #(.ADDR_W(4), .SYNC_STAGES(3), .MODE(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .gray_ptr_remote(gray_in), .bin_ptr_local(loc_in),
        .err_clr(err_clr), .ptr_sync_gray(o_gray[2]), .ptr_sync_bin(o_bin[2]),
        .ptr_update(o_upd[2]), .level(o_level[2]), .flag(o_flag[2]),
        .almost_flag(o_almost[2]), .err(o_err[2]));

    ptr_sync_status #(.ADDR_W(4), .SYNC_STAGES(4), .MODE(0)) dut3 (
        .clk(clk), .rst_n(rst_n), .gray_ptr_remote(gray_in), .bin_ptr_local(loc_in),
        .err_clr(err_clr), .ptr_sync_gray(o_gray[3]), .ptr_sync_bin(o_bin[3]),
        .ptr_update(o_upd[3]), .level(o_level[3]), .flag(o_flag[3]),
        .almost_flag(o_almost[3]), .err(o_err[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: input history indexed by the number of edges since reset release.
    int         k;
    logic [4:0] rem_h [HMAX];
    logic [4:0] loc_h [HMAX];
    logic [1:0] err_m [ND];

    function automatic int rem_at(int j);
        return (j < 1) ? 0 : int'(rem_h[j]);
    endfunction

    function automatic int g2b(int g);
        return (g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3) ^ (g >> 4)) & 31;
    endfunction

    function automatic int e_gray(int s, int j);
        return rem_at(j - s + 1);
    endfunction

    function automatic int e_bin(int s, int j);
        return g2b(rem_at(j - s));
    endfunction

    function automatic int e_level(int m, int s, int j);
        if (j < 1) return 0;
        if (m == 0) return (int'(loc_h[j]) - e_bin(s, j - 1)) & 31;
        return (e_bin(s, j - 1) - int'(loc_h[j])) & 31;
    endfunction

    function automatic int e_flag(int m, int s, int j);
        if (j < 1) return (m == 1) ? 1 : 0;
        if (m == 0) return (e_level(m, s, j) == 16) ? 1 : 0;
        return (e_level(m, s, j) == 0) ? 1 : 0;
    endfunction

    function automatic int e_almost(int m, int s, int j);
        if (j < 1) return (m == 1) ? 1 : 0;
        if (m == 0) return (e_level(m, s, j) >= 14) ? 1 : 0;
        return (e_level(m, s, j) <= 2) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0;
            for (int d = 0; d < ND; d++) err_m[d] = 2'b00;
        end else if (k < HMAX - 1) begin
            k = k + 1;
            rem_h[k] = gray_in;
            loc_h[k] = loc_in;
            for (int d = 0; d < ND; d++) begin
                logic lv, jp;
                lv = e_level(MODE_C[d], SYNC_C[d], k) > 16;
                jp = ((e_bin(SYNC_C[d], k) - e_bin(SYNC_C[d], k - 1)) & 31) > 16;
                if (err_clr) err_m[d] = 2'b00;
                err_m[d] = err_m[d] | {lv, jp};
            end
        end
    end

    task automatic chk(input string name, input int d, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%0d exp=%0d (t=%0t)", name, d, got, exp, $time);
        end
    endtask

    bit run_cmp = 1'b0;

    always @(negedge clk) begin
        if (run_cmp) begin
            for (int d = 0; d < ND; d++) begin
                int m, s, up;
                m  = MODE_C[d];
                s  = SYNC_C[d];
                up = (k >= 1 && e_bin(s, k) != e_bin(s, k - 1)) ? 1 : 0;
                chk("gray",   d, int'(o_gray[d]),   e_gray(s, k));
                chk("bin",    d, int'(o_bin[d]),    e_bin(s, k));
                chk("update", d, int'(o_upd[d]),    up);
                chk("level",  d, int'(o_level[d]),  e_level(m, s, k));
                chk("flag",   d, int'(o_flag[d]),   e_flag(m, s, k));
                chk("almost", d, int'(o_almost[d]), e_almost(m, s, k));
                chk("err",    d, int'(o_err[d]),    int'(err_m[d]));
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    localparam int NV = 6;
    localparam logic [4:0] VG [NV] = '{5'd0, 5'd1, 5'd2, 5'd7, 5'd12, 5'd10};
    localparam logic [4:0] VL [NV] = '{5'd2, 5'd3, 5'd6, 5'd9, 5'd12, 5'd2};
    localparam logic       VC [NV] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        rst_n   = 1'b0;
        gray_in = 5'd0;
        loc_in  = 5'd0;
        err_clr = 1'b0;
        run_cmp = 1'b1;
        tick(2);
        chk("rst_flag_m0",   0, int'(o_flag[0]),   0);
        chk("rst_flag_m1",   1, int'(o_flag[1]),   1);
        chk("rst_almost_m1", 1, int'(o_almost[1]), 1);
        chk("rst_level",     0, int'(o_level[0]),  0);
        rst_n = 1'b1;

        // Local pointer sweep with remote held at zero.
        for (int i = 0; i <= 16; i++) begin
            loc_in = 5'(i);
            tick(1);
            chk("sweep_level",  0, int'(o_level[0]),  i);
            chk("sweep_almost", 0, int'(o_almost[0]), (i >= 14) ? 1 : 0);
            chk("sweep_full",   0, int'(o_flag[0]),   (i == 16) ? 1 : 0);
        end

        // Remote Gray 0 -> 1 -> 3 with local 0; latency per stage depth.
        loc_in  = 5'd0;
        gray_in = 5'd1;
        tick(1);
        chk("lat_gray_e1", 1, int'(o_gray[1]), 0);
        tick(1);
        chk("lat_gray_e2", 1, int'(o_gray[1]), 1);
        chk("lat3_gray_e2", 2, int'(o_gray[2]), 0);
        tick(1);
        chk("lat_upd_e3",  1, int'(o_upd[1]),  1);
        chk("lat_bin_e3",  1, int'(o_bin[1]),  1);
        chk("lat_empty_e3", 1, int'(o_flag[1]), 1);
        chk("lat3_gray_e3", 2, int'(o_gray[2]), 1);
        chk("lat4_gray_e3", 3, int'(o_gray[3]), 0);
        tick(1);
        chk("lat_empty_e4", 1, int'(o_flag[1]),  0);
        chk("lat_level_e4", 1, int'(o_level[1]), 1);
        chk("lat_upd_e4",   1, int'(o_upd[1]),   0);
        chk("lat4_gray_e4", 3, int'(o_gray[3]), 1);
        gray_in = 5'd3;
        tick(4);
        chk("step_level", 1, int'(o_level[1]), 2);

        // Wrap: remote bin 17 (Gray 25), local 31 -> 0.
        gray_in = 5'd25;
        tick(4);
        loc_in = 5'd31;
        tick(1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(1);
        chk("wrap_level_pre", 0, int'(o_level[0]), 14);
        chk("wrap_err_pre",   0, int'(o_err[0]),   0);
        loc_in = 5'd0;
        tick(1);
        chk("wrap_level", 0, int'(o_level[0]), 15);
        chk("wrap_err",   0, int'(o_err[0]),   0);

        // Remote jump 0 -> 20 (Gray 30).
        gray_in = 5'd0;
        tick(4);
        chk("jump_err_pre", 0, int'(o_err[0]), 0);
        gray_in = 5'd30;
        tick(3);
        chk("jump_err_set", 0, int'(o_err[0]), 1);
        tick(3);
        chk("jump_err_hold", 0, int'(o_err[0]), 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("jump_err_clr", 0, int'(o_err[0]), 0);

        // Full, then asynchronous reset in the middle of a cycle.
        loc_in = 5'd4;
        tick(1);
        chk("pre_rst_full",   0, int'(o_flag[0]),   1);
        chk("pre_rst_almost", 0, int'(o_almost[0]), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_full",  0, int'(o_flag[0]),  0);
        chk("rst_async_level", 0, int'(o_level[0]), 0);
        chk("rst_async_bin",   0, int'(o_bin[0]),   0);
        chk("rst_async_empty", 1, int'(o_flag[1]),  1);
        chk("rst_async_gray",  3, int'(o_gray[3]),  0);
        tick(1);
        chk("rst_hold_empty", 1, int'(o_flag[1]), 1);
        rst_n = 1'b1;

        // Remote and local moving together, with some err_clr overlap.
        for (int v = 0; v < NV; v++) begin
            gray_in = VG[v];
            loc_in  = VL[v];
            err_clr = VC[v];
            tick(1);
            err_clr = 1'b0;
            tick(2);
        end
        tick(8);

        run_cmp = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ptr_sync_status.md
PTR_SYNC_STATUS -- requirements
Module: ptr_sync_status

Interface
REQ-001 Parameter ADDR_W, default 4: FIFO address width; DEPTH = 2^ADDR_W; pointer width PW = ADDR_W+1.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flop count; legal 2..4.
REQ-003 Parameter MODE, default 0: 0 = write side (full flags), 1 = read side (empty flags).
REQ-004 Parameter AF_LEVEL, default DEPTH-2: almost-full threshold, used when MODE=0.
REQ-005 Parameter AE_LEVEL, default 2: almost-empty threshold, used when MODE=1.
REQ-006 clk  in  1  single clock, local domain; all flops on rising edge.
REQ-007 rst_n  in  1  asynchronous assert, active-low reset.
REQ-008 gray_ptr_remote  in  PW  remote-domain Gray pointer, asynchronous to clk.
REQ-009 bin_ptr_local  in  PW  local binary pointer next-value, synchronous to clk.
REQ-010 err_clr  in  1  clears sticky error bits.
REQ-011 ptr_sync_gray  out  PW  synchronised remote Gray pointer.
REQ-012 ptr_sync_bin  out  PW  binary conversion of ptr_sync_gray, registered.
REQ-013 ptr_update  out  1  one-cycle pulse when ptr_sync_bin changes.
REQ-014 level  out  PW  occupancy, 0..DEPTH.
REQ-015 flag  out  1  full (MODE=0) or empty (MODE=1).
REQ-016 almost_flag  out  1  almost-full (MODE=0) or almost-empty (MODE=1).
REQ-017 err  out  2  sticky {level_err, jump_err}.

Function
REQ-018 Synchroniser: SYNC_STAGES-deep flop chain on gray_ptr_remote with no logic between stages; last stage drives ptr_sync_gray.
REQ-019 Remote change reaches ptr_sync_gray after SYNC_STAGES edges; ptr_sync_bin after SYNC_STAGES+1; level/flag/almost_flag after SYNC_STAGES+2.
REQ-020 Gray-to-binary: bin[PW-1] = g[PW-1]; bin[i] = bin[i+1] XOR g[i].
REQ-021 ptr_update = 1 for exactly one cycle when the registered ptr_sync_bin differs from its previous value.
REQ-022 Level arithmetic modulo 2^PW: MODE=0 level = bin_ptr_local - ptr_sync_bin; MODE=1 level = ptr_sync_bin - bin_ptr_local; level, flag and almost_flag are registered.
REQ-023 A change on bin_ptr_local is reflected in level/flags on the next edge, aligned with the local pointer register.
REQ-024 MODE=0: flag = (level == DEPTH); almost_flag = (level >= AF_LEVEL).
REQ-025 MODE=1: flag = (level == 0); almost_flag = (level <= AE_LEVEL).
REQ-026 Pointer wrap: pointer roll-over from 2^PW-1 to 0 gives the correct level through the modulo arithmetic; no special case.
REQ-027 level_err sets when the computed level > DEPTH; level output still shows the raw value.
REQ-028 jump_err sets when (new ptr_sync_bin - previous ptr_sync_bin) mod 2^PW > DEPTH.
REQ-029 err bits stay set until err_clr = 1; a new error on the same cycle as err_clr leaves the bit set.
REQ-030 Remote and local pointers moving on the same cycle: each is applied per its own latency; no event is lost.

Reset
REQ-031 rst_n low clears all synchroniser, binary, level and error flops to 0 asynchronously.
REQ-032 Output values while in reset: ptr_sync_gray = 0, ptr_sync_bin = 0, ptr_update = 0, level = 0, err = 0.
REQ-033 Flag values while in reset: MODE=0 flag = 0 and almost_flag = 0; MODE=1 flag = 1 and almost_flag = 1.
REQ-034 Reset asserted mid-operation drops all pending synchroniser contents; normal operation resumes from zero pointers on the first edge after deassertion.

Verification
REQ-035 MODE=0, ADDR_W=4, SYNC_STAGES=2: remote Gray 0 held; bin_ptr_local steps 0..16 -> level tracks one edge later; almost_flag rises at level 14; flag rises at level 16.
REQ-036 MODE=1: remote Gray steps 0 -> 1 -> 3 (bin 0, 1, 2) with local 0 -> ptr_sync_gray updates 2 edges after each step, ptr_update pulses at edge 3, flag falls at edge 4, level = 2.
REQ-037 Wrap: local pointer 31 -> 0 while synced remote pointer = 17 (MODE=0) -> level goes 14 -> 15, err = 0.
REQ-038 Remote jump: remote bin 0 -> 20 in one step -> jump_err = 1 and stays set; err_clr pulse -> err = 00 one edge later.
REQ-039 Reset pulse during active flags -> all outputs at reset values immediately; MODE=1 flag = 1 while rst_n is low.
REQ-040 SYNC_STAGES = 3 and 4: remote step -> ptr_sync_gray latency of 3 and 4 edges respectively.
